// File: rtl/drm_activator_stream_if.sv
// User-IP endpoint of the DRM controller AXI4-Stream pair: decodes commands,
// holds the activation code, meters usage events and returns response words.
module drm_activator_stream_if #(
   parameter int C_DATA_WIDTH   = 32,
   parameter int C_CODE_WORDS   = 4,
   parameter int C_LOAD_TIMEOUT = 1024
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst,
   input  logic                       drm_to_uip_tvalid,
   output logic                       drm_to_uip_tready,
   input  logic [C_DATA_WIDTH-1:0]    drm_to_uip_tdata,
   output logic                       uip_to_drm_tvalid,
   input  logic                       uip_to_drm_tready,
   output logic [C_DATA_WIDTH-1:0]    uip_to_drm_tdata,
   input  logic                       usage_event,
   output logic                       activated,
   output logic [C_CODE_WORDS*32-1:0] activation_code
);

   localparam int IDX_W = 4;
   localparam int TO_W  = $clog2(C_LOAD_TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_CODE_WORDS - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(C_LOAD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RESP,
      S_RESP_HI
   } state_e;

   typedef enum logic [3:0] {
      OP_WRITE_CODE  = 4'h1,
      OP_READ_STATUS = 4'h2,
      OP_READ_COUNT  = 4'h3,
      OP_CLEAR_COUNT = 4'h4
   } opcode_e;

   state_e           state;
   logic [IDX_W-1:0] load_idx;
   logic [TO_W-1:0]  load_timeout;
   logic [63:0]      usage_count;
   logic [31:0]      count_hi;
   logic [3:0]       op;
   logic             cmd_xfer;
   logic             rsp_xfer;
   logic             clear_cnt;

   always_comb begin
      op        = drm_to_uip_tdata[31:28];
      cmd_xfer  = drm_to_uip_tvalid && drm_to_uip_tready;
      rsp_xfer  = uip_to_drm_tvalid && uip_to_drm_tready;
      clear_cnt = (state == S_IDLE) && cmd_xfer && (op == OP_CLEAR_COUNT);
   end

   // Clear has priority over a coincident usage event; count saturates.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         usage_count <= '0;
      end else if (clear_cnt) begin
         usage_count <= '0;
      end else if (usage_event && activated && (usage_count != '1)) begin
         usage_count <= usage_count + 64'd1;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state             <= S_IDLE;
         drm_to_uip_tready <= 1'b0;
         uip_to_drm_tvalid <= 1'b0;
         uip_to_drm_tdata  <= '0;
         activated         <= 1'b0;
         activation_code   <= '0;
         load_idx          <= '0;
         load_timeout      <= '0;
         count_hi          <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               drm_to_uip_tready <= 1'b1;
               if (cmd_xfer) begin
                  case (op)
                     OP_WRITE_CODE: begin
                        activated    <= 1'b0;
                        load_idx     <= '0;
                        load_timeout <= '0;
                        state        <= S_LOAD;
                     end
                     OP_READ_STATUS: begin
                        drm_to_uip_tready <= 1'b0;
                        uip_to_drm_tvalid <= 1'b1;
                        uip_to_drm_tdata  <= {4'hB, 11'h0, activated, 16'(C_CODE_WORDS)};
                        state             <= S_RESP;
                     end
                     OP_READ_COUNT: begin
                        // High half captured with the low half so the pair is coherent.
                        drm_to_uip_tready <= 1'b0;
                        uip_to_drm_tvalid <= 1'b1;
                        uip_to_drm_tdata  <= usage_count[31:0];
                        count_hi          <= usage_count[63:32];
                        state             <= S_RESP_HI;
                     end
                     OP_CLEAR_COUNT: begin
                        drm_to_uip_tready <= 1'b0;
                        uip_to_drm_tvalid <= 1'b1;
                        uip_to_drm_tdata  <= 32'hA000_0000;
                        state             <= S_RESP;
                     end
                     default: begin
                        drm_to_uip_tready <= 1'b0;
                        uip_to_drm_tvalid <= 1'b1;
                        uip_to_drm_tdata  <= 32'hE000_0001 | {4'h0, op, 24'h0};
                        state             <= S_RESP;
                     end
                  endcase
               end
            end

            S_LOAD: begin
               if (cmd_xfer) begin
                  activation_code[32*int'(load_idx) +: 32] <= drm_to_uip_tdata[31:0];
                  load_idx     <= load_idx + 1'b1;
                  load_timeout <= '0;
                  if (load_idx == LAST_IDX) begin
                     activated         <= 1'b1;
                     drm_to_uip_tready <= 1'b0;
                     uip_to_drm_tvalid <= 1'b1;
                     uip_to_drm_tdata  <= 32'hA000_0000 | 32'(C_CODE_WORDS);
                     state             <= S_RESP;
                  end
               end else if (load_timeout == TO_LAST) begin
                  drm_to_uip_tready <= 1'b0;
                  uip_to_drm_tvalid <= 1'b1;
                  uip_to_drm_tdata  <= 32'hE000_0002;
                  state             <= S_RESP;
               end else begin
                  load_timeout <= load_timeout + 1'b1;
               end
            end

            S_RESP_HI: begin
               if (rsp_xfer) begin
                  uip_to_drm_tdata <= count_hi;
                  state            <= S_RESP;
               end
            end

            S_RESP: begin
               if (rsp_xfer) begin
                  uip_to_drm_tvalid <= 1'b0;
                  drm_to_uip_tready <= 1'b1;
                  state             <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_drm_activator_stream_if.sv
// Bench for drm_activator_stream_if: directed sequences, a command table and
// randomized command traffic checked against a transaction-level model.
module tb_drm_activator_stream_if;

   localparam int CW = 4;
   localparam int TO = 16;
   localparam int BOUND = 4 * TO;

   logic              ap_clk = 1'b0;
   logic              ap_rst = 1'b1;
   logic              drm_to_uip_tvalid = 1'b0;
   logic              drm_to_uip_tready;
   logic [31:0]       drm_to_uip_tdata = '0;
   logic              uip_to_drm_tvalid;
   logic              uip_to_drm_tready = 1'b0;
   logic [31:0]       uip_to_drm_tdata;
   logic              usage_event = 1'b0;
   logic              activated;
   logic [CW*32-1:0]  activation_code;

   always #5 ap_clk = ~ap_clk;

   drm_activator_stream_if #(
      .C_DATA_WIDTH  (32),
      .C_CODE_WORDS  (CW),
      .C_LOAD_TIMEOUT(TO)
   ) dut (
      .ap_clk           (ap_clk),
      .ap_rst           (ap_rst),
      .drm_to_uip_tvalid(drm_to_uip_tvalid),
      .drm_to_uip_tready(drm_to_uip_tready),
      .drm_to_uip_tdata (drm_to_uip_tdata),
      .uip_to_drm_tvalid(uip_to_drm_tvalid),
      .uip_to_drm_tready(uip_to_drm_tready),
      .uip_to_drm_tdata (uip_to_drm_tdata),
      .usage_event      (usage_event),
      .activated        (activated),
      .activation_code  (activation_code)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction-level model of the endpoint's architectural state.
   logic [31:0] m_code [CW];
   bit          m_act;
   logic [63:0] m_cnt;

   typedef struct {
      logic [31:0] hdr;
      int          nresp;
      logic [31:0] exp0;
      logic [31:0] exp1;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [CW*32-1:0] m_code_flat();
      logic [CW*32-1:0] r;
      for (int i = 0; i < CW; i++) r[i*32 +: 32] = m_code[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < CW; i++) m_code[i] = '0;
      m_act = 1'b0;
      m_cnt = '0;
   endtask

   task automatic check(input string name, input logic [CW*32-1:0] act, input logic [CW*32-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      int n;
      n = 0;
      drm_to_uip_tvalid = 1'b1;
      drm_to_uip_tdata  = w;
      while (!drm_to_uip_tready && n < BOUND) begin
         @(negedge ap_clk);
         n++;
      end
      if (!drm_to_uip_tready) begin
         check("send_word tready timeout", 1'b0, 1'b1);
         drm_to_uip_tvalid = 1'b0;
         return;
      end
      @(posedge ap_clk);
      #1;
      drm_to_uip_tvalid = 1'b0;
   endtask

   task automatic recv_word(input int stall, output logic [31:0] w);
      int n;
      n = 0;
      while (!uip_to_drm_tvalid && n < BOUND) begin
         @(negedge ap_clk);
         n++;
      end
      if (!uip_to_drm_tvalid) begin
         check("recv_word tvalid timeout", 1'b0, 1'b1);
         w = 'x;
         return;
      end
      w = uip_to_drm_tdata;
      for (int i = 0; i < stall; i++) begin
         @(negedge ap_clk);
         check("stall tvalid held", uip_to_drm_tvalid, 1'b1);
         check("stall tdata stable", uip_to_drm_tdata, w);
      end
      uip_to_drm_tready = 1'b1;
      @(posedge ap_clk);
      #1;
      uip_to_drm_tready = 1'b0;
   endtask

   task automatic pulse_event();
      @(negedge ap_clk);
      usage_event = 1'b1;
      @(negedge ap_clk);
      usage_event = 1'b0;
      if (m_act && m_cnt != '1) m_cnt = m_cnt + 64'd1;
   endtask

   task automatic write_code(input int max_gap);
      logic [31:0] r;
      logic [31:0] p;
      send_word({4'h1, 28'($urandom)});
      m_act = 1'b0;
      for (int i = 0; i < CW; i++) begin
         p = $urandom;
         repeat ($urandom_range(0, max_gap)) @(negedge ap_clk);
         send_word(p);
         m_code[i] = p;
      end
      m_act = 1'b1;
      recv_word($urandom_range(0, 2), r);
      check("write_code resp", r, 32'hA000_0000 | CW);
      check("write_code activated", activated, m_act);
      check("write_code code", activation_code, m_code_flat());
   endtask

   task automatic read_count(input int stall, input string name);
      logic [31:0] lo, hi;
      send_word(32'h3000_0000);
      recv_word(stall, lo);
      recv_word(stall, hi);
      check({name, " count lo"}, lo, m_cnt[31:0]);
      check({name, " count hi"}, hi, m_cnt[63:32]);
   endtask

   task automatic simple_cmd(input logic [31:0] hdr, input logic [31:0] exp, input string name);
      logic [31:0] r;
      send_word(hdr);
      recv_word($urandom_range(0, 2), r);
      check(name, r, exp);
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic [31:0] w [CW];
      int n;
      int op;

      model_reset();

      // Reset values while ap_rst is held
      repeat (3) @(negedge ap_clk);
      check("reset tready", drm_to_uip_tready, 1'b0);
      check("reset tvalid", uip_to_drm_tvalid, 1'b0);
      check("reset tdata", uip_to_drm_tdata, 32'h0);
      check("reset activated", activated, 1'b0);
      check("reset code", activation_code, '0);
      ap_rst = 1'b0;

      // Back-to-back code load
      for (int i = 0; i < CW; i++) w[i] = 32'h1111_1111 * (i + 1);
      send_word(32'h1000_0000);
      for (int i = 0; i < CW; i++) begin
         if (i == CW - 1) check("activated before last word", activated, 1'b0);
         send_word(w[i]);
         m_code[i] = w[i];
      end
      m_act = 1'b1;
      check("activated after last word", activated, 1'b1);
      check("resp valid after last word", uip_to_drm_tvalid, 1'b1);
      check("code loaded", activation_code, 128'h44444444_33333333_22222222_11111111);
      recv_word(0, r);
      check("write_code ack", r, 32'hA000_0004);

      // Metering and count read with back-pressure
      repeat (5) pulse_event();
      read_count(3, "stalled");

      // Command table from a known state: activated, count = 5
      vecs[0] = '{32'h2000_0000, 1, 32'hB001_0004, 32'h0};
      vecs[1] = '{32'h3000_0000, 2, 32'h0000_0005, 32'h0};
      vecs[2] = '{32'h7000_0000, 1, 32'hE700_0001, 32'h0};
      vecs[3] = '{32'hF123_4567, 1, 32'hEF00_0001, 32'h0};
      vecs[4] = '{32'h0000_0000, 1, 32'hE000_0001, 32'h0};
      vecs[5] = '{32'h4000_0000, 1, 32'hA000_0000, 32'h0};
      vecs[6] = '{32'h3ABC_DEF0, 2, 32'h0000_0000, 32'h0};
      vecs[7] = '{32'h2FFF_FFFF, 1, 32'hB001_0004, 32'h0};
      for (int i = 0; i < 8; i++) begin
         send_word(vecs[i].hdr);
         recv_word(i % 3, r);
         check($sformatf("table[%0d] word0", i), r, vecs[i].exp0);
         if (vecs[i].nresp == 2) begin
            recv_word(0, r);
            check($sformatf("table[%0d] word1", i), r, vecs[i].exp1);
         end
         check($sformatf("table[%0d] activated", i), activated, 1'b1);
      end
      m_cnt = '0;

      // Load timeout after one payload word
      send_word(32'h1000_0000);
      send_word(32'hDEAD_BEEF);
      m_act = 1'b0;
      m_code[0] = 32'hDEAD_BEEF;
      n = 0;
      while (!uip_to_drm_tvalid && n < BOUND) begin
         @(posedge ap_clk);
         #1;
         n++;
      end
      check("timeout latency", n, TO);
      recv_word(1, r);
      check("timeout resp", r, 32'hE000_0002);
      check("timeout activated", activated, 1'b0);
      check("timeout code", activation_code, m_code_flat());
      repeat (3) pulse_event();
      read_count(0, "inactive");
      simple_cmd(32'h7000_0000, 32'hE700_0001, "unknown 0x7");
      simple_cmd(32'h2000_0000, 32'hB000_0004, "status inactive");

      // Saturation, then clear colliding with an event
      write_code(0);
      @(negedge ap_clk);
      force dut.usage_count = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.usage_count;
      m_cnt = '1;
      pulse_event();
      read_count(1, "saturated");
      @(negedge ap_clk);
      force dut.usage_count = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.usage_count;
      usage_event = 1'b1;
      send_word(32'h4000_0000);
      usage_event = 1'b0;
      m_cnt = '0;
      recv_word(0, r);
      check("clear ack", r, 32'hA000_0000);
      read_count(0, "after clear");

      // Asynchronous reset in the middle of a load
      send_word(32'h1000_0000);
      send_word(32'hAAAA_0001);
      send_word(32'hAAAA_0002);
      #2;
      ap_rst = 1'b1;
      #1;
      check("async rst tready", drm_to_uip_tready, 1'b0);
      check("async rst tvalid", uip_to_drm_tvalid, 1'b0);
      check("async rst tdata", uip_to_drm_tdata, 32'h0);
      check("async rst activated", activated, 1'b0);
      check("async rst code", activation_code, '0);
      model_reset();
      @(negedge ap_clk);
      ap_rst = 1'b0;
      write_code(0);

      // Randomized command traffic against the model
      for (int t = 0; t < 60; t++) begin
         repeat ($urandom_range(0, 4)) pulse_event();
         op = $urandom_range(0, 4);
         case (op)
            0: write_code(3);
            1: simple_cmd({4'h2, 28'($urandom)}, {4'hB, 11'h0, m_act, 16'(CW)}, "rand status");
            2: read_count($urandom_range(0, 2), "rand");
            3: begin
               m_cnt = '0;
               simple_cmd({4'h4, 28'($urandom)}, 32'hA000_0000, "rand clear");
            end
            default: begin
               n = $urandom_range(5, 16);
               if (n == 16) n = 0;
               simple_cmd({4'(n), 28'($urandom)}, 32'hE000_0001 | (32'(n) << 24), "rand unknown");
            end
         endcase
         check("rand activated", activated, m_act);
         check("rand code", activation_code, m_code_flat());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
